// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl
//   Run sequencer for an N x N systolic array of floating-point MAC PEs.
//   A run is IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE:
//     CLEAR  one cycle of pe_clr to zero every accumulator
//     FEED   skewed operand window of k_len + 2(N-1) + PE_LAT cycles so the
//            last PE receives its last operand and the MAC pipeline flushes
//     DRAIN  one result row per valid/ready handshake, row 0 first
//     DONE   single-cycle done pulse
//   abort returns to IDLE from any busy state without a done pulse.
//   Every output is a flop loaded from the next-state decode, so outputs
//   only ever change on a clock edge and line up with the state register.
//
//   Optional feature macro: SYSCTRL_PERF_EN
//     defined   : perf_cycles counts the busy cycles of the latest run
//     undefined : perf_cycles is tied to zero and the counter is not built
// ---------------------------------------------------------------------------
module systolic_seq_ctrl #(
    parameter int N      = 4,
    parameter int K_MAX  = 64,
    parameter int PE_LAT = 3,
    localparam int KW    = $clog2(K_MAX + 1),
    localparam int DRW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [KW-1:0]  k_len,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           pe_clr,
    output logic           pe_en,
    output logic [15:0]    feed_t,
    output logic [N-1:0]   row_valid,
    output logic [N-1:0]   col_valid,
    output logic [DRW-1:0] drain_row,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [31:0]    perf_cycles
);

    // Cycles the feed window needs on top of k_len: skew in to the far
    // corner PE (N-1 rows + N-1 cols) plus the MAC pipeline flush.
    localparam int FEED_EXTRA = 2 * (N - 1) + PE_LAT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [KW-1:0]  k_len_q_reg;
    logic [KW-1:0]  k_len_q_next;
    logic [15:0]    feed_t_reg;
    logic [15:0]    feed_t_next;
    logic [DRW-1:0] drain_row_reg;
    logic [DRW-1:0] drain_row_next;

    logic           busy_reg;
    logic           busy_next;
    logic           done_reg;
    logic           done_next;
    logic           pe_clr_reg;
    logic           pe_clr_next;
    logic           pe_en_reg;
    logic           pe_en_next;
    logic           res_valid_reg;
    logic           res_valid_next;
    logic [N-1:0]   row_valid_reg;
    logic [N-1:0]   col_valid_reg;
    logic [N-1:0]   lane_valid_next;

    logic [KW-1:0]  k_len_clamped;
    logic [15:0]    feed_last;
    logic           drain_fire;

    // Oversized requests are clamped so the feed window never exceeds
    // what the operand buffers hold.
    assign k_len_clamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

    // Index of the final feed cycle (window length minus one).
    assign feed_last = 16'(k_len_q_reg) + 16'(FEED_EXTRA - 1);

    assign drain_fire = res_valid_reg && res_ready;

    // Next-state and counter update; abort overrides everything else.
    always_comb begin
        state_next     = state_reg;
        k_len_q_next   = k_len_q_reg;
        feed_t_next    = feed_t_reg;
        drain_row_next = drain_row_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_CLEAR;
                    k_len_q_next = k_len_clamped;
                end
            end
            S_CLEAR: begin
                state_next  = S_FEED;
                feed_t_next = '0;
            end
            S_FEED: begin
                if (feed_t_reg == feed_last) begin
                    state_next     = S_DRAIN;
                    feed_t_next    = '0;
                    drain_row_next = '0;
                end else begin
                    feed_t_next = feed_t_reg + 16'd1;
                end
            end
            S_DRAIN: begin
                if (drain_fire) begin
                    if (drain_row_reg == DRW'(N - 1)) begin
                        state_next     = S_DONE;
                        drain_row_next = '0;
                    end else begin
                        drain_row_next = drain_row_reg + DRW'(1);
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (abort && (state_reg != S_IDLE)) begin
            state_next     = S_IDLE;
            feed_t_next    = '0;
            drain_row_next = '0;
        end
    end

    // Output decode from the upcoming state so the registered outputs
    // are valid in the same cycle the state register enters that state.
    always_comb begin
        busy_next      = (state_next != S_IDLE);
        done_next      = (state_next == S_DONE);
        pe_clr_next    = (state_next == S_CLEAR);
        pe_en_next     = (state_next == S_FEED);
        res_valid_next = (state_next == S_DRAIN);
    end

    // Per-lane skew: lane i carries operand k = t - i, valid while
    // 0 <= t - i < k_len.  Rows and columns share the same schedule.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign lane_valid_next[gi] = (state_next == S_FEED)
                                      && (feed_t_next >= 16'(gi))
                                      && ((feed_t_next - 16'(gi)) < 16'(k_len_q_next));
        end
    endgenerate

    // State, captured length and run counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            k_len_q_reg   <= '0;
            feed_t_reg    <= '0;
            drain_row_reg <= '0;
        end else begin
            state_reg     <= state_next;
            k_len_q_reg   <= k_len_q_next;
            feed_t_reg    <= feed_t_next;
            drain_row_reg <= drain_row_next;
        end
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            pe_clr_reg    <= 1'b0;
            pe_en_reg     <= 1'b0;
            res_valid_reg <= 1'b0;
            row_valid_reg <= '0;
            col_valid_reg <= '0;
        end else begin
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            pe_clr_reg    <= pe_clr_next;
            pe_en_reg     <= pe_en_next;
            res_valid_reg <= res_valid_next;
            row_valid_reg <= lane_valid_next;
            col_valid_reg <= lane_valid_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign pe_clr    = pe_clr_reg;
    assign pe_en     = pe_en_reg;
    assign feed_t    = feed_t_reg;
    assign row_valid = row_valid_reg;
    assign col_valid = col_valid_reg;
    assign drain_row = drain_row_reg;
    assign res_valid = res_valid_reg;

`ifdef SYSCTRL_PERF_EN
    logic [31:0] perf_reg;

    // Busy-cycle counter: zeroed on start accept, counts every non-IDLE
    // cycle, and holds the last run's total while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_reg <= '0;
        end else if (state_reg == S_IDLE) begin
            if (start) begin
                perf_reg <= '0;
            end
        end else begin
            perf_reg <= perf_reg + 32'd1;
        end
    end

    assign perf_cycles = perf_reg;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_seq_ctrl
//   Self-checking bench for systolic_seq_ctrl (N=4, K_MAX=64, PE_LAT=3).
//   A timeline model derives every expected output from the run's cycle
//   index since start accept and the number of drain handshakes seen.
//   A vector table fixes feed length and done cycle per scenario; hand
//   sequences cover reset, feed skew, busy-cycle count and async reset.
// ---------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

    localparam int N      = 4;
    localparam int K_MAX  = 64;
    localparam int PE_LAT = 3;
    localparam int KW     = 7;
    localparam int BOUND  = 2000;

`ifdef SYSCTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          pe_clr;
    logic          pe_en;
    logic [15:0]   feed_t;
    logic [N-1:0]  row_valid;
    logic [N-1:0]  col_valid;
    logic [1:0]    drain_row;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   perf_cycles;

    int n_cmp = 0;
    int n_bad = 0;
    int perf_exp = 0;
    logic [N-1:0] rv_log [0:127];
    logic [N-1:0] cv_log [0:127];

    typedef struct {
        int k;
        int stall_row;
        int stall_len;
        int abort_t;
        int exp_feed;
        int exp_done;
    } vec_t;

    vec_t tbl [9];

    systolic_seq_ctrl #(
        .N      (N),
        .K_MAX  (K_MAX),
        .PE_LAT (PE_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .pe_clr      (pe_clr),
        .pe_en       (pe_en),
        .feed_t      (feed_t),
        .row_valid   (row_valid),
        .col_valid   (col_valid),
        .drain_row   (drain_row),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .perf_cycles (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [62:0] pack_act();
        return {busy, done, pe_clr, pe_en, feed_t, row_valid, col_valid,
                drain_row, res_valid, perf_cycles};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One run from start accept until three idle cycles have been seen.
    // Expected outputs come from the run timeline: cycle 1 clear, cycles
    // 2..F+1 feed with t = c-2, then one drain row per handshake, then done.
    task automatic run_case(input int k, input int stall_row, input int stall_len,
                            input int abort_t, input bit rnd,
                            output int feed_len, output int done_cyc);
        int kq, f, c, rows, stall_left, idle_seen, done_c, tt;
        bit aborted, hs, in_drain;
        logic e_busy, e_done, e_clr, e_en, e_rv;
        logic [15:0] e_t;
        logic [N-1:0] e_lanes;
        logic [1:0] e_row;
        logic [31:0] e_perf;

        kq = (k > K_MAX) ? K_MAX : k;
        f  = kq + 2 * (N - 1) + PE_LAT;
        rows = 0; stall_left = stall_len; idle_seen = 0; done_c = -1;
        aborted = 1'b0; feed_len = 0; done_cyc = -1;

        start = 1'b1; k_len = k[KW-1:0]; abort = 1'b0; res_ready = 1'b0;
        @(posedge clk); #1;
        perf_exp = 0;
        start = 1'b0;

        for (c = 1; c < BOUND && idle_seen < 3; c++) begin
            e_busy = 0; e_done = 0; e_clr = 0; e_en = 0; e_rv = 0;
            e_t = '0; e_row = '0; e_lanes = '0; tt = 0; in_drain = 1'b0;
            if (aborted) begin
                e_busy = 0;
            end else if (c == 1) begin
                e_busy = 1; e_clr = 1;
            end else if (c <= f + 1) begin
                e_busy = 1; e_en = 1; tt = c - 2; e_t = 16'(tt);
                for (int i = 0; i < N; i++)
                    e_lanes[i] = (tt >= i) && (tt - i < kq);
            end else if (rows < N) begin
                e_busy = 1; e_rv = 1; e_row = 2'(rows); in_drain = 1'b1;
            end else if (c == done_c) begin
                e_busy = 1; e_done = 1;
            end
            e_perf = PERF ? 32'(perf_exp) : 32'd0;
            check($sformatf("k=%0d cyc=%0d", k, c), {1'b0, pack_act()},
                  {1'b0, e_busy, e_done, e_clr, e_en, e_t, e_lanes, e_lanes,
                   e_row, e_rv, e_perf});

            if (e_en) begin
                feed_len++;
                rv_log[tt] = row_valid;
                cv_log[tt] = col_valid;
            end
            if (e_done) done_cyc = c;
            if (!e_busy) idle_seen++;

            // inputs for the coming edge
            abort = e_en && (tt == abort_t);
            if (in_drain && !rnd && rows == stall_row && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else if (in_drain && !rnd) begin
                res_ready = 1'b1;
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
            start = e_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            k_len = e_busy ? KW'($urandom) : k[KW-1:0];
            hs = in_drain && res_ready;

            if (e_busy) perf_exp++;
            if (abort) aborted = 1'b1;
            if (hs) begin
                rows++;
                if (rows == N) done_c = c + 1;
            end
            @(posedge clk); #1;
        end
        if (c >= BOUND) begin
            n_cmp++; n_bad++;
            $display("FAIL run_timeout k=%0d: got %0d cycles want < %0d", k, c, BOUND);
        end
        start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        $display("run k=%0d abort_t=%0d feed_cycles=%0d done_cycle=%0d", k, abort_t, feed_len, done_cyc);
    endtask

    initial begin
        int fl, dc, kr, ar;
        logic [3:0] skew_exp [0:12] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                        4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                        4'b0000, 4'b0000, 4'b0000};

        tbl[0] = '{k: 4,   stall_row: -1, stall_len: 0, abort_t: -1, exp_feed: 13, exp_done: 19};
        tbl[1] = '{k: 4,   stall_row: 2,  stall_len: 5, abort_t: -1, exp_feed: 13, exp_done: 24};
        tbl[2] = '{k: 0,   stall_row: -1, stall_len: 0, abort_t: -1, exp_feed: 9,  exp_done: 15};
        tbl[3] = '{k: 100, stall_row: -1, stall_len: 0, abort_t: -1, exp_feed: 73, exp_done: 79};
        tbl[4] = '{k: 64,  stall_row: -1, stall_len: 0, abort_t: -1, exp_feed: 73, exp_done: 79};
        tbl[5] = '{k: 65,  stall_row: -1, stall_len: 0, abort_t: -1, exp_feed: 73, exp_done: 79};
        tbl[6] = '{k: 1,   stall_row: 0,  stall_len: 3, abort_t: -1, exp_feed: 10, exp_done: 19};
        tbl[7] = '{k: 4,   stall_row: -1, stall_len: 0, abort_t: 5,  exp_feed: 6,  exp_done: -1};
        tbl[8] = '{k: 4,   stall_row: -1, stall_len: 0, abort_t: -1, exp_feed: 13, exp_done: 19};

        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; k_len = '0;
        #2;
        check("reset_state", {1'b0, pack_act()}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {1'b0, pack_act()}, 64'd0);

        // Feed skew and busy-cycle count for the reference k_len=4 run.
        run_case(4, -1, 0, -1, 1'b0, fl, dc);
        for (int t = 0; t < 13; t++) begin
            check($sformatf("skew_row t=%0d", t), 64'(rv_log[t]), 64'(skew_exp[t]));
            check($sformatf("skew_col t=%0d", t), 64'(cv_log[t]), 64'(skew_exp[t]));
        end
        check("perf_after_done", 64'(perf_cycles), PERF ? 64'd19 : 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_case(tbl[i].k, tbl[i].stall_row, tbl[i].stall_len, tbl[i].abort_t, 1'b0, fl, dc);
            check($sformatf("tbl%0d_feed_len", i), 64'(fl), 64'(tbl[i].exp_feed));
            check($sformatf("tbl%0d_done_cyc", i), 64'(dc), 64'(tbl[i].exp_done));
        end

        // Asynchronous reset in the middle of DRAIN.
        start = 1'b1; k_len = '0; res_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("pre_rst_drain", {62'd0, busy, res_valid}, 64'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_immediate", {1'b0, pack_act()}, 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_async_rst", {1'b0, pack_act()}, 64'd0);

        // Randomized runs: random lengths, random backpressure, some aborts.
        for (int r = 0; r < 10; r++) begin
            kr = int'($urandom_range(0, 80));
            ar = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            run_case(kr, -1, 0, ar, 1'b1, fl, dc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
